// File: rtl/edid_pkg.sv
// Shared constants and state encodings for the multi-block EDID fetcher.
// Imported by edid_fetch_multi and edid_byte_reader.
package edid_pkg;

    localparam int         EDID_BLK_BYTES    = 128;
    localparam int         EDID_EXT_IDX      = 126;
    localparam logic [7:0] EDID_DEV_ADDR_DEF = 8'hA0;
    localparam logic [7:0] EDID_SEG_ADDR_DEF = 8'h60;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_SEG,
        ST_SEG_W,
        ST_SEGB,
        ST_SEGB_W,
        ST_ADDR,
        ST_ADDR_W,
        ST_OFS,
        ST_OFS_W,
        ST_RDS,
        ST_RDS_W,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_BLK_DONE,
        ST_STOP_W,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } edid_state_t;

    typedef enum logic {
        XFER_START,
        XFER_BYTE
    } xfer_op_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_START,
        RD_NEXT,
        RD_DEAD,
        RD_WAIT
    } rd_state_t;

endpackage

// File: rtl/edid_byte_reader.sv
// One i2c_master handshake per request: a (repeated) start with device address,
// or a single byte write/read. Reports done on m_ready, err on m_ack_err.
module edid_byte_reader
    import edid_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = EDID_DEV_ADDR_DEF
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic       i_go,
    input  xfer_op_t   i_op,
    input  logic [7:0] i_dev_addr,
    input  logic       i_rw,
    input  logic [7:0] i_wdata,
    input  logic       i_nak,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_dev_addr,
    output logic       o_rw,
    output logic       o_start,
    output logic       o_next,
    output logic       o_nak,
    output logic [7:0] o_wdata,
    input  logic       i_ready,
    input  logic       i_idle,
    input  logic       i_ack_err
);

    rd_state_t  r_state, w_nxt;
    logic [7:0] r_dev_addr;
    logic       r_rw;
    logic [7:0] r_wdata;
    logic       r_nak;

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) r_state <= RD_IDLE;
        else      r_state <= w_nxt;
    end

    // Address and direction persist across byte requests until the next start.
    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            r_dev_addr <= DEV_ADDR;
            r_rw       <= 1'b0;
            r_wdata    <= 8'd0;
            r_nak      <= 1'b0;
        end else if (r_state == RD_IDLE && i_go) begin
            if (i_op == XFER_START) begin
                r_dev_addr <= i_dev_addr;
                r_rw       <= i_rw;
            end
            r_wdata <= i_wdata;
            r_nak   <= i_nak;
        end
    end

    always_comb begin
        w_nxt   = r_state;
        o_done  = 1'b0;
        o_err   = 1'b0;
        o_start = 1'b0;
        o_next  = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (i_go) w_nxt = (i_op == XFER_START) ? RD_START : RD_NEXT;
            end
            RD_START: begin
                // Held until the master leaves idle; one cycle on a repeated start.
                o_start = 1'b1;
                if (i_ack_err) begin
                    o_err = 1'b1;
                    w_nxt = RD_IDLE;
                end else if (!i_idle) begin
                    w_nxt = RD_DEAD;
                end
            end
            RD_NEXT: begin
                o_next = 1'b1;
                w_nxt  = RD_DEAD;
            end
            RD_DEAD: begin
                if (i_ack_err) begin
                    o_err = 1'b1;
                    w_nxt = RD_IDLE;
                end else begin
                    w_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (i_ack_err) begin
                    o_err = 1'b1;
                    w_nxt = RD_IDLE;
                end else if (i_ready) begin
                    o_done = 1'b1;
                    w_nxt  = RD_IDLE;
                end
            end
            default: w_nxt = RD_IDLE;
        endcase
    end

    assign o_dev_addr = r_dev_addr;
    assign o_rw       = r_rw;
    assign o_nak      = r_nak;
    assign o_wdata    = r_wdata;

endmodule

// File: rtl/edid_fetch_multi.sv
// Copies 1..MAX_BLOCKS EDID blocks from the monitor into edid_mem via i2c_master.
// Define EDID_CKSUM_EN to also retry blocks whose byte sum is non-zero.
module edid_fetch_multi
    import edid_pkg::*;
#(
    parameter int         MAX_BLOCKS = 2,
    parameter logic [7:0] DEV_ADDR   = EDID_DEV_ADDR_DEF,
    parameter logic [7:0] SEG_ADDR   = EDID_SEG_ADDR_DEF,
    parameter int         RETRY_MAX  = 3,
    localparam int        AW         = $clog2(MAX_BLOCKS * EDID_BLK_BYTES)
) (
    input  logic          gclk,
    input  logic          rst,
    input  logic          edid_init,
    output logic          edid_ok,
    output logic          edid_err,
    output logic [3:0]    blocks_valid,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          mem_wren,
    output logic [7:0]    m_dev_addr,
    output logic          m_rw,
    output logic          m_start,
    output logic          m_stop,
    output logic          m_next,
    output logic          m_nak,
    output logic [7:0]    m_wdata,
    input  logic [7:0]    m_rdata,
    input  logic          m_ready,
    input  logic          m_idle,
    input  logic          m_ack_err
);

    edid_state_t   r_state, w_nxt;
    logic [2:0]    r_blk;
    logic [3:0]    r_nblk;
    logic [3:0]    r_retry;
    logic [3:0]    r_bv;
    logic [6:0]    r_idx;
    logic          r_bad;
    logic          r_init_d;
    logic          r_ok;
    logic          r_err;
    logic          r_wren;
    logic [AW-1:0] r_waddr;
    logic [7:0]    r_wdata;

    logic          w_go;
    xfer_op_t      w_op;
    logic [7:0]    w_dev;
    logic          w_rw;
    logic [7:0]    w_wd;
    logic          w_nak;
    logic          w_stop;
    logic          w_done;
    logic          w_err;
    logic          w_bad;
    logic [3:0]    w_blk_inc;
    logic [3:0]    w_retry_inc;
    logic [8:0]    w_ext;
    logic [3:0]    w_nblk_cap;

    assign w_blk_inc   = {1'b0, r_blk} + 4'd1;
    assign w_retry_inc = r_retry + 4'd1;
    // Nine bits so an extension count of 255 cannot wrap before the clamp.
    assign w_ext       = {1'b0, m_rdata} + 9'd1;
    assign w_nblk_cap  = (w_ext > 9'(MAX_BLOCKS)) ? 4'(MAX_BLOCKS) : w_ext[3:0];

`ifdef EDID_CKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst)                                r_sum <= 8'd0;
        else if (r_state == ST_SEG)              r_sum <= 8'd0;
        else if (r_state == ST_RD_WAIT && w_done) r_sum <= r_sum + m_rdata;
    end

    assign w_bad = r_bad | (r_sum != 8'd0);
`else
    assign w_bad = r_bad;
`endif

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_nxt;
    end

    always_comb begin
        w_nxt  = r_state;
        w_go   = 1'b0;
        w_op   = XFER_BYTE;
        w_dev  = DEV_ADDR;
        w_rw   = 1'b0;
        w_wd   = 8'd0;
        w_nak  = 1'b0;
        w_stop = 1'b0;
        case (r_state)
            ST_IDLE: if (edid_init) w_nxt = ST_SEG;
            // Resting states: a fresh rising edge is needed so a held level cannot loop.
            ST_DONE, ST_FAIL: if (edid_init && !r_init_d) w_nxt = ST_SEG;
            ST_SEG: begin
                if (r_blk < 3'd2) begin
                    w_nxt = ST_ADDR;
                end else begin
                    w_go  = 1'b1;
                    w_op  = XFER_START;
                    w_dev = SEG_ADDR;
                    w_nxt = ST_SEG_W;
                end
            end
            ST_SEG_W:  if (w_err) w_nxt = ST_BLK_DONE; else if (w_done) w_nxt = ST_SEGB;
            ST_SEGB: begin
                w_go  = 1'b1;
                w_wd  = {6'd0, r_blk[2:1]};
                w_nxt = ST_SEGB_W;
            end
            ST_SEGB_W: if (w_err) w_nxt = ST_BLK_DONE; else if (w_done) w_nxt = ST_ADDR;
            ST_ADDR: begin
                w_go  = 1'b1;
                w_op  = XFER_START;
                w_nxt = ST_ADDR_W;
            end
            ST_ADDR_W: if (w_err) w_nxt = ST_BLK_DONE; else if (w_done) w_nxt = ST_OFS;
            ST_OFS: begin
                w_go  = 1'b1;
                w_wd  = {r_blk[0], 7'd0};
                w_nxt = ST_OFS_W;
            end
            ST_OFS_W:  if (w_err) w_nxt = ST_BLK_DONE; else if (w_done) w_nxt = ST_RDS;
            ST_RDS: begin
                w_go  = 1'b1;
                w_op  = XFER_START;
                w_rw  = 1'b1;
                w_nxt = ST_RDS_W;
            end
            ST_RDS_W:  if (w_err) w_nxt = ST_BLK_DONE; else if (w_done) w_nxt = ST_RD_REQ;
            ST_RD_REQ: begin
                w_go  = 1'b1;
                w_nak = (r_idx == 7'd127);
                w_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_err)       w_nxt = ST_BLK_DONE;
                else if (w_done) w_nxt = (r_idx == 7'd127) ? ST_BLK_DONE : ST_RD_REQ;
            end
            ST_BLK_DONE: begin
                w_stop = 1'b1;
                w_nxt  = ST_STOP_W;
            end
            ST_STOP_W: if (m_idle) w_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!w_bad) w_nxt = (w_blk_inc == r_nblk) ? ST_DONE : ST_SEG;
                else        w_nxt = (w_retry_inc == 4'(RETRY_MAX)) ? ST_FAIL : ST_SEG;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            r_blk    <= 3'd0;
            r_nblk   <= 4'd0;
            r_retry  <= 4'd0;
            r_bv     <= 4'd0;
            r_idx    <= 7'd0;
            r_bad    <= 1'b0;
            r_init_d <= 1'b0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_wren   <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 8'd0;
        end else begin
            r_wren   <= 1'b0;
            r_init_d <= edid_init;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (w_nxt == ST_SEG) begin
                        r_ok    <= 1'b0;
                        r_err   <= 1'b0;
                        r_bv    <= 4'd0;
                        r_blk   <= 3'd0;
                        r_nblk  <= 4'd1;
                        r_retry <= 4'd0;
                    end
                end
                ST_SEG: begin
                    r_idx <= 7'd0;
                    r_bad <= 1'b0;
                end
                ST_RD_WAIT: begin
                    if (w_done) begin
                        r_waddr <= AW'({r_blk, r_idx});
                        r_wdata <= m_rdata;
                        r_wren  <= 1'b1;
                        r_idx   <= r_idx + 7'd1;
                        if (MAX_BLOCKS > 1 && r_blk == 3'd0 && r_idx == 7'(EDID_EXT_IDX))
                            r_nblk <= w_nblk_cap;
                    end
                end
                ST_CHECK: begin
                    if (!w_bad) begin
                        r_bv    <= r_bv + 4'd1;
                        r_retry <= 4'd0;
                        r_blk   <= r_blk + 3'd1;
                        if (w_blk_inc == r_nblk) r_ok <= 1'b1;
                    end else begin
                        r_retry <= w_retry_inc;
                        if (w_retry_inc == 4'(RETRY_MAX)) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_err) r_bad <= 1'b1;
        end
    end

    edid_byte_reader #(
        .DEV_ADDR (DEV_ADDR)
    ) u_rd (
        .gclk       (gclk),
        .rst        (rst),
        .i_go       (w_go),
        .i_op       (w_op),
        .i_dev_addr (w_dev),
        .i_rw       (w_rw),
        .i_wdata    (w_wd),
        .i_nak      (w_nak),
        .o_done     (w_done),
        .o_err      (w_err),
        .o_dev_addr (m_dev_addr),
        .o_rw       (m_rw),
        .o_start    (m_start),
        .o_next     (m_next),
        .o_nak      (m_nak),
        .o_wdata    (m_wdata),
        .i_ready    (m_ready),
        .i_idle     (m_idle),
        .i_ack_err  (m_ack_err)
    );

    assign edid_ok      = r_ok;
    assign edid_err     = r_err;
    assign blocks_valid = r_bv;
    assign mem_waddr    = r_waddr;
    assign mem_wdata    = r_wdata;
    assign mem_wren     = r_wren;
    assign m_stop       = w_stop;

endmodule
